// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes and the skip-zero op-class helper.
// Also used by the control unit.
package cpu_pkg;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    // Ops whose zero indication looks at the result rather than operand A.
    function automatic logic skz_on_result(input logic [2:0] op);
        return (op == OP_HLT) || (op == OP_SKZ) || (op == OP_STO) || (op == OP_JMP);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational WIDTH-bit ALU: result, carry out of ADD, and skip-zero indication.
module alu_core
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        result = a;
        cout   = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                cout   = sum[WIDTH];
            end
            OP_AND:  result = a & b;
            OP_XOR:  result = a ^ b;
            OP_LDA:  result = b;
            default: result = a;
        endcase
        zero = skz_on_result(op) ? (result == '0) : (a == '0);
    end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready on both sides, 1 or 2 stages, and a sticky carry flag
// for multi-precision ADD chains.
module alu_pipe
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PIPE  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       alu_op,
    input  logic             cin_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             skz_cmp,
    output logic             carry,
    output logic             carry_flag
);

    if (PIPE != 1 && PIPE != 2) begin : g_bad_pipe
        $error("alu_pipe: PIPE must be 1 or 2");
    end

    logic [WIDTH-1:0] core_result;
    logic             core_cout;
    logic             core_zero;
    logic             carry_flag_q;
    logic             init_q;
    logic             v1_q;
    logic [WIDTH-1:0] res1_q;
    logic             skz1_q;
    logic             cy1_q;
    logic             rdy_down;
    logic             rdy1;
    logic             accept;

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a      (in_a),
        .b      (in_b),
        .op     (alu_op),
        .cin    (cin_en & carry_flag_q),
        .result (core_result),
        .cout   (core_cout),
        .zero   (core_zero)
    );

    // init_q keeps in_ready low until the first edge after reset release.
    assign rdy1     = !v1_q || rdy_down;
    assign in_ready = init_q && rdy1;
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q       <= 1'b0;
            v1_q         <= 1'b0;
            res1_q       <= '0;
            skz1_q       <= 1'b0;
            cy1_q        <= 1'b0;
            carry_flag_q <= 1'b0;
        end else begin
            init_q <= 1'b1;
            if (flush) begin
                v1_q <= 1'b0;
            end else if (rdy1) begin
                v1_q <= accept;
            end
            if (accept) begin
                res1_q <= core_result;
                skz1_q <= core_zero;
                cy1_q  <= core_cout;
            end
            if (flush) begin
                carry_flag_q <= 1'b0;
            end else if (accept && alu_op == OP_ADD) begin
                carry_flag_q <= core_cout;
            end
        end
    end

    assign carry_flag = carry_flag_q;

    if (PIPE == 2) begin : g_pipe2
        logic             v2_q;
        logic [WIDTH-1:0] res2_q;
        logic             skz2_q;
        logic             cy2_q;

        assign rdy_down = !v2_q || out_ready;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v2_q   <= 1'b0;
                res2_q <= '0;
                skz2_q <= 1'b0;
                cy2_q  <= 1'b0;
            end else begin
                if (flush) begin
                    v2_q <= 1'b0;
                end else if (rdy_down) begin
                    v2_q <= v1_q;
                end
                if (rdy_down && v1_q) begin
                    res2_q <= res1_q;
                    skz2_q <= skz1_q;
                    cy2_q  <= cy1_q;
                end
            end
        end

        assign out_valid = v2_q;
        assign result    = res2_q;
        assign skz_cmp   = skz2_q;
        assign carry     = cy2_q;
    end else begin : g_pipe1
        assign rdy_down  = out_ready;
        assign out_valid = v1_q;
        assign result    = res1_q;
        assign skz_cmp   = skz1_q;
        assign carry     = cy1_q;
    end

endmodule
